// File: rtl/irda_uart_receiver.sv
// IrDA SIR receiver: synchronizes the pulse line, decodes one bit per
// OVERSAMPLE ticks and frames start/data/stop into bytes.
module irda_uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 irda_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BCW = $clog2(DATA_BITS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic                 sync1;
    logic                 rx_s;
    logic [3:0]           tick_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic                 pulse_seen;
    logic [DATA_BITS-1:0] shift;
    logic                 bit_val;
    logic                 win_end;

    // Any pulse seen in the window decodes as a 0 bit.
    assign bit_val = ~(pulse_seen | rx_s);
    assign win_end = sample_tick && (tick_cnt == 4'(OVERSAMPLE - 1));
    assign busy    = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            rx_s  <= 1'b0;
        end else begin
            sync1 <= irda_rx;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            pulse_seen <= 1'b0;
            shift      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (sample_tick) begin
                if (state == IDLE) begin
                    if (rx_s) begin
                        state      <= START;
                        tick_cnt   <= 4'd1;
                        pulse_seen <= 1'b1;
                    end
                end else if (win_end) begin
                    tick_cnt   <= '0;
                    pulse_seen <= 1'b0;
                    unique case (state)
                        START: begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                        DATA: begin
                            shift   <= {bit_val, shift[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BCW'(DATA_BITS - 1))
                                state <= STOP;
                        end
                        STOP: begin
                            if (bit_val) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end else begin
                    tick_cnt   <= tick_cnt + 1'b1;
                    pulse_seen <= pulse_seen | rx_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_irda_uart_receiver.sv
// Directed bench for irda_uart_receiver: frames built tick by tick,
// expected bytes and pulse counts written by hand.
module tb_irda_uart_receiver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sample_tick = 1'b0;
    logic       irda_rx = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int compared = 0;
    int mismatched = 0;
    int nvalid = 0;
    int nerr = 0;
    int nboth = 0;
    logic [7:0] got[$];
    bit lv[$];

    irda_uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .sample_tick(sample_tick),
        .irda_rx    (irda_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            if (rx_valid) begin
                nvalid++;
                got.push_back(rx_data);
            end
            if (frame_err) nerr++;
            if (rx_valid && frame_err) nboth++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sample period: line level held 3 clocks, then a tick clock.
    task automatic tick(input bit lvl);
        irda_rx = lvl;
        sample_tick = 1'b0;
        repeat (3) @(negedge clock);
        sample_tick = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0;
    endtask

    function automatic void add_window(input bit b);
        for (int t = 0; t < 16; t++) lv.push_back(!b && t < 3);
    endfunction

    function automatic void add_frame(input logic [7:0] d, input bit bad_stop);
        add_window(1'b0);
        for (int i = 0; i < 8; i++) add_window(d[i]);
        add_window(!bad_stop);
    endfunction

    task automatic play(input int n);
        for (int i = 0; i < n && i < lv.size(); i++) tick(lv[i]);
        lv.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_data", rx_data, 8'h00);
        check("reset_valid", rx_valid, 0);
        check("reset_err", frame_err, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        idle(2);

        // Ideal 0xA5
        add_frame(8'hA5, 1'b0);
        play(80);
        check("a5_busy_mid", busy, 1);
        add_frame(8'hA5, 1'b0);
        for (int i = 80; i < 160; i++) tick(lv[i]);
        lv.delete();
        idle(2);
        check("a5_nvalid", nvalid, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_busy_after", busy, 0);

        // Back-to-back 0x00, 0xFF
        add_frame(8'h00, 1'b0);
        add_frame(8'hFF, 1'b0);
        play(320);
        idle(2);
        check("b2b_nvalid", nvalid, 3);
        check("b2b_first", got.size() > 1 ? got[1] : 8'hxx, 8'h00);
        check("b2b_second", got.size() > 2 ? got[2] : 8'hxx, 8'hFF);

        // 0x5A with a pulse in the stop window
        add_frame(8'h5A, 1'b1);
        play(160);
        idle(2);
        check("ferr_nerr", nerr, 1);
        check("ferr_nvalid", nvalid, 3);
        check("ferr_data_kept", rx_data, 8'hFF);

        // Reset during data bit 4, coinciding with a tick
        add_frame(8'h3C, 1'b0);
        play(85);
        check("rst_busy_before", busy, 1);
        reset = 1'b1;
        sample_tick = 1'b1;
        irda_rx = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sample_tick = 1'b0;
        irda_rx = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_data", rx_data, 8'h00);
        idle(2);
        check("rst_no_valid", nvalid, 3);
        check("rst_no_err", nerr, 1);
        add_frame(8'h3C, 1'b0);
        play(160);
        idle(2);
        check("rst_next_nvalid", nvalid, 4);
        check("rst_next_data", rx_data, 8'h3C);

        // Pulse between ticks while idle
        irda_rx = 1'b1;
        @(negedge clock);
        irda_rx = 1'b0;
        repeat (4) @(negedge clock);
        idle(3);
        check("glitch_busy", busy, 0);
        check("glitch_nvalid", nvalid, 4);

        // Pulse straddling data bit 2 / bit 3 boundary in 0xFF
        add_frame(8'hFF, 1'b0);
        lv[63] = 1'b1;
        lv[64] = 1'b1;
        play(160);
        idle(2);
        check("strad_nvalid", nvalid, 5);
        check("strad_data", rx_data, 8'hF3);

        check("never_both", nboth, 0);
        check("total_err", nerr, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
